regfile_sb: RTL and testbench

Parametrised successor to the CPU's 12-bit three-ported register file. Adds a second write port for late load writeback, same-cycle write bypass and a PC-substituted top register. Adds a load scoreboard that tracks pending destinations and generates the decode stall. Sits between decode (read, issue) and the execute/memory writeback paths.

---
 rtl/regfile_sb_if.sv | 42 ++++
 rtl/regfile_sb.sv | 133 +++++++++++++
 tb/tb_regfile_sb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode / writeback paths and the regfile_sb register file.
// Carries both write ports, both read ports, PC substitute and scoreboard signals.
interface regfile_sb_if #(
    parameter int DATA_W = 12,
    parameter int NREGS  = 4
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS) + 1;

    logic              we_a;
    logic [AW-1:0]     wa_a;
    logic [DATA_W-1:0] wd_a;
    logic              we_b;
    logic [AW-1:0]     wa_b;
    logic [DATA_W-1:0] wd_b;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] pc_in;
    logic              issue_ld;
    logic [AW-1:0]     issue_dst;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic [CW-1:0]     pend_cnt;
    logic              err;

    // Load issue handshake: issue_ld is the valid, !stall is the ready; a load
    // destination is accepted only on a rising edge where both are high.
    modport master (
        output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, pc_in,
               issue_ld, issue_dst,
        input  rd1, rd2, busy1, busy2, stall, pend_cnt, err
    );

    modport slave (
        input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, pc_in,
               issue_ld, issue_dst,
        output rd1, rd2, busy1, busy2, stall, pend_cnt, err
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-write / two-read register file with PC-aliased top index, optional write
// bypass, and a load scoreboard that produces the decode stall.
module regfile_sb #(
    parameter int DATA_W = 12,
    parameter int NREGS  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS) + 1;
    localparam int NS = NREGS - 1;
    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [DATA_W-1:0] regs_q [NS];
    logic [DATA_W-1:0] regs_d [NS];
    logic [NS-1:0]     pend_q;
    logic [NS-1:0]     pend_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              err_q;
    logic              err_d;

    logic [DATA_W-1:0] arr1;
    logic [DATA_W-1:0] arr2;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic              issue_ok;

    function automatic logic is_stored(input logic [AW-1:0] a);
        return int'(a) < NS;
    endfunction

    // Out-of-range and PC indices read as not pending.
    function automatic logic pend_at(input logic [NS-1:0] p, input logic [AW-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (a == AW'(i)) r = p[i];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     ra,
        input logic [DATA_W-1:0] arr,
        input logic [DATA_W-1:0] pc,
        input logic              wea,
        input logic [AW-1:0]     waa,
        input logic [DATA_W-1:0] wda,
        input logic              web,
        input logic [AW-1:0]     wab,
        input logic [DATA_W-1:0] wdb
    );
        logic [DATA_W-1:0] r;
        if (ra == PC_IDX)                 r = pc;
        else if (BYPASS && wea && waa == ra) r = wda;
        else if (BYPASS && web && wab == ra) r = wdb;
        else                              r = arr;
        return r;
    endfunction

    always_comb begin
        arr1 = '0;
        arr2 = '0;
        for (int i = 0; i < NS; i++) begin
            if (bus.ra1 == AW'(i)) arr1 = regs_q[i];
            if (bus.ra2 == AW'(i)) arr2 = regs_q[i];
        end
    end

    assign bus.rd1 = read_port(bus.ra1, arr1, bus.pc_in, bus.we_a, bus.wa_a, bus.wd_a,
                               bus.we_b, bus.wa_b, bus.wd_b);
    assign bus.rd2 = read_port(bus.ra2, arr2, bus.pc_in, bus.we_a, bus.wa_a, bus.wd_a,
                               bus.we_b, bus.wa_b, bus.wd_b);

    // A load return arriving this cycle satisfies the reader only when it is forwarded.
    assign busy1 = pend_at(pend_q, bus.ra1) && !(BYPASS && bus.we_b && bus.wa_b == bus.ra1);
    assign busy2 = pend_at(pend_q, bus.ra2) && !(BYPASS && bus.we_b && bus.wa_b == bus.ra2);
    assign stall = busy1 || busy2 || (bus.issue_ld && pend_at(pend_q, bus.issue_dst));
    assign issue_ok = bus.issue_ld && !stall;

    assign bus.busy1    = busy1;
    assign bus.busy2    = busy2;
    assign bus.stall    = stall;
    assign bus.pend_cnt = cnt_q;
    assign bus.err      = err_q;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < NS; i++) begin
            // Port A applied last so it wins an address collision.
            if (bus.we_b && bus.wa_b == AW'(i)) regs_d[i] = bus.wd_b;
            if (bus.we_a && bus.wa_a == AW'(i)) regs_d[i] = bus.wd_a;
            // Set after clear so a same-cycle reissue keeps the bit pending.
            if (bus.we_b && bus.wa_b == AW'(i)) pend_d[i] = 1'b0;
            if (issue_ok && bus.issue_dst == AW'(i)) pend_d[i] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NS; i++) begin
            cnt_d = cnt_d + CW'(pend_d[i]);
        end
    end

    always_comb begin
        err_d = err_q;
        if (bus.we_b && is_stored(bus.wa_b) && !pend_at(pend_q, bus.wa_b)) err_d = 1'b1;
        if (bus.we_a && pend_at(pend_q, bus.wa_a))                         err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance driven in
// lockstep, checked every cycle against a behavioural model plus literal checks.
module tb_regfile_sb;
  localparam int DW = 12;
  localparam int NR = 4;
  localparam int PC = NR - 1;

  logic clk;
  logic reset;

  logic          we_a, we_b, issue_ld;
  logic [1:0]    wa_a, wa_b, ra1, ra2, issue_dst;
  logic [DW-1:0] wd_a, wd_b, pc_in;

  int total = 0;
  int bad   = 0;

  regfile_sb_if #(.DATA_W(DW), .NREGS(NR)) if1 ();
  regfile_sb_if #(.DATA_W(DW), .NREGS(NR)) if0 ();

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  regfile_sb #(.DATA_W(DW), .NREGS(NR), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

  assign if1.we_a = we_a;  assign if0.we_a = we_a;
  assign if1.wa_a = wa_a;  assign if0.wa_a = wa_a;
  assign if1.wd_a = wd_a;  assign if0.wd_a = wd_a;
  assign if1.we_b = we_b;  assign if0.we_b = we_b;
  assign if1.wa_b = wa_b;  assign if0.wa_b = wa_b;
  assign if1.wd_b = wd_b;  assign if0.wd_b = wd_b;
  assign if1.ra1 = ra1;    assign if0.ra1 = ra1;
  assign if1.ra2 = ra2;    assign if0.ra2 = ra2;
  assign if1.pc_in = pc_in; assign if0.pc_in = pc_in;
  assign if1.issue_ld = issue_ld;   assign if0.issue_ld = issue_ld;
  assign if1.issue_dst = issue_dst; assign if0.issue_dst = issue_dst;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index b = BYPASS value) ----------------
  logic [DW-1:0] mem [2][NR];
  bit            pend [2][NR];
  bit            merr [2];

  function automatic logic [DW-1:0] m_read(int b, int ra);
    if (ra == PC) return pc_in;
    if (b == 1 && we_a && int'(wa_a) == ra) return wd_a;
    if (b == 1 && we_b && int'(wa_b) == ra) return wd_b;
    return mem[b][ra];
  endfunction

  function automatic bit m_busy(int b, int ra);
    if (ra == PC) return 1'b0;
    return pend[b][ra] && !(b == 1 && we_b && int'(wa_b) == ra);
  endfunction

  function automatic bit m_stall(int b);
    return m_busy(b, int'(ra1)) || m_busy(b, int'(ra2)) || (issue_ld && pend[b][issue_dst]);
  endfunction

  function automatic int m_cnt(int b);
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(pend[b][i]);
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NR; i++) begin
          mem[b][i]  = '0;
          pend[b][i] = 1'b0;
        end
        merr[b] = 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        bit st;
        st = m_stall(b);
        if (we_b && int'(wa_b) != PC && !pend[b][wa_b]) merr[b] = 1'b1;
        if (we_a && int'(wa_a) != PC && pend[b][wa_a])  merr[b] = 1'b1;
        if (we_b && int'(wa_b) != PC) mem[b][wa_b] = wd_b;
        if (we_a && int'(wa_a) != PC) mem[b][wa_a] = wd_a;
        if (we_b && int'(wa_b) != PC) pend[b][wa_b] = 1'b0;
        if (issue_ld && !st && int'(issue_dst) != PC) pend[b][issue_dst] = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("rd1_bp1",   32'(if1.rd1),   32'(m_read(1, int'(ra1))));
      check("rd2_bp1",   32'(if1.rd2),   32'(m_read(1, int'(ra2))));
      check("busy1_bp1", 32'(if1.busy1), 32'(m_busy(1, int'(ra1))));
      check("busy2_bp1", 32'(if1.busy2), 32'(m_busy(1, int'(ra2))));
      check("stall_bp1", 32'(if1.stall), 32'(m_stall(1)));
      check("cnt_bp1",   32'(if1.pend_cnt), 32'(m_cnt(1)));
      check("err_bp1",   32'(if1.err),   32'(merr[1]));
      check("rd1_bp0",   32'(if0.rd1),   32'(m_read(0, int'(ra1))));
      check("rd2_bp0",   32'(if0.rd2),   32'(m_read(0, int'(ra2))));
      check("busy1_bp0", 32'(if0.busy1), 32'(m_busy(0, int'(ra1))));
      check("busy2_bp0", 32'(if0.busy2), 32'(m_busy(0, int'(ra2))));
      check("stall_bp0", 32'(if0.stall), 32'(m_stall(0)));
      check("cnt_bp0",   32'(if0.pend_cnt), 32'(m_cnt(0)));
      check("err_bp0",   32'(if0.err),   32'(merr[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    we_a = 0; wa_a = 0; wd_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0;
    ra1 = 0; ra2 = 0; pc_in = 0;
    issue_ld = 0; issue_dst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    #2;
    do_reset();

    // reset state and PC alias
    ra1 = 0; ra2 = 2;
    at_neg();
    check("lit_rst_rd1", 32'(if1.rd1), 32'h0);
    check("lit_rst_rd2", 32'(if1.rd2), 32'h0);
    check("lit_rst_cnt", 32'(if1.pend_cnt), 32'h0);
    check("lit_rst_err", 32'(if1.err), 32'h0);
    tick();
    ra1 = 3; pc_in = 12'h108;
    at_neg();
    check("lit_pc_bp1", 32'(if1.rd1), 32'h108);
    check("lit_pc_bp0", 32'(if0.rd1), 32'h108);

    // same-cycle bypass vs array
    tick();
    idle(); we_a = 1; wa_a = 1; wd_a = 12'hABC; ra1 = 1;
    at_neg();
    check("lit_byp_bp1", 32'(if1.rd1), 32'hABC);
    check("lit_byp_bp0", 32'(if0.rd1), 32'h0);
    tick();
    idle(); ra1 = 1;
    at_neg();
    check("lit_arr_bp1", 32'(if1.rd1), 32'hABC);
    check("lit_arr_bp0", 32'(if0.rd1), 32'hABC);

    // port collision: A wins; B to non-pending r2 flags err
    tick();
    idle(); we_a = 1; wa_a = 2; wd_a = 12'h111; we_b = 1; wa_b = 2; wd_b = 12'h222; ra1 = 2;
    at_neg();
    check("lit_coll_byp", 32'(if1.rd1), 32'h111);
    tick();
    idle(); ra1 = 2;
    at_neg();
    check("lit_coll_bp1", 32'(if1.rd1), 32'h111);
    check("lit_coll_bp0", 32'(if0.rd1), 32'h111);
    check("lit_coll_err", 32'(if1.err), 32'h1);
    tick();
    do_reset();
    at_neg();
    check("lit_err_clr", 32'(if1.err), 32'h0);

    // load issue then return
    tick();
    idle(); issue_ld = 1; issue_dst = 0;
    tick();
    idle(); ra1 = 0;
    at_neg();
    check("lit_ld_busy", 32'(if1.busy1), 32'h1);
    check("lit_ld_stall", 32'(if1.stall), 32'h1);
    check("lit_ld_cnt", 32'(if1.pend_cnt), 32'h1);
    tick();
    idle(); ra1 = 0; we_b = 1; wa_b = 0; wd_b = 12'h5A5;
    at_neg();
    check("lit_ret_busy_bp1", 32'(if1.busy1), 32'h0);
    check("lit_ret_rd_bp1", 32'(if1.rd1), 32'h5A5);
    check("lit_ret_busy_bp0", 32'(if0.busy1), 32'h1);
    check("lit_ret_rd_bp0", 32'(if0.rd1), 32'h0);
    tick();
    idle(); ra1 = 0;
    at_neg();
    check("lit_ret_cnt", 32'(if1.pend_cnt), 32'h0);
    check("lit_ret_rd", 32'(if0.rd1), 32'h5A5);
    check("lit_ret_err", 32'(if1.err), 32'h0);

    // WAW stall and set-wins-over-clear
    tick();
    idle(); issue_ld = 1; issue_dst = 1;
    tick();
    idle(); issue_ld = 1; issue_dst = 1;
    at_neg();
    check("lit_waw_stall", 32'(if1.stall), 32'h1);
    check("lit_waw_cnt", 32'(if1.pend_cnt), 32'h1);
    tick();
    idle();
    at_neg();
    check("lit_waw_cnt2", 32'(if1.pend_cnt), 32'h1);
    tick();
    idle(); we_b = 1; wa_b = 1; wd_b = 12'h0F0; issue_ld = 1; issue_dst = 1;
    at_neg();
    check("lit_clr_stall", 32'(if1.stall), 32'h1);
    tick();
    idle();
    at_neg();
    check("lit_clr_cnt", 32'(if1.pend_cnt), 32'h0);
    tick();
    idle(); we_b = 1; wa_b = 1; wd_b = 12'h0F1; issue_ld = 1; issue_dst = 1;
    at_neg();
    check("lit_set_stall", 32'(if1.stall), 32'h0);
    tick();
    idle(); ra1 = 1;
    at_neg();
    check("lit_set_busy", 32'(if1.busy1), 32'h1);
    check("lit_set_cnt", 32'(if1.pend_cnt), 32'h1);
    check("lit_set_err", 32'(if1.err), 32'h1);

    // sticky err and asynchronous mid-cycle reset
    tick();
    do_reset();
    we_a = 1; wa_a = 0; wd_a = 12'h777;
    tick();
    idle(); issue_ld = 1; issue_dst = 0;
    tick();
    idle(); we_b = 1; wa_b = 2; wd_b = 12'h333;
    tick();
    idle(); ra1 = 2;
    at_neg();
    check("lit_sticky_err", 32'(if1.err), 32'h1);
    check("lit_sticky_cnt", 32'(if1.pend_cnt), 32'h1);
    tick();
    idle(); we_a = 1; wa_a = 1; wd_a = 12'h444;
    tick();
    idle(); ra1 = 0;
    #1;
    check("lit_pre_rst_rd", 32'(if1.rd1), 32'h777);
    check("lit_pre_rst_err", 32'(if1.err), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("lit_async_rd", 32'(if1.rd1), 32'h0);
    check("lit_async_err", 32'(if1.err), 32'h0);
    check("lit_async_cnt", 32'(if1.pend_cnt), 32'h0);
    tick();
    reset = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int pl[$];
      tick();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 119) == 0) begin
        reset = 1'b1;
      end
      pl.delete();
      for (int i = 0; i < NR; i++) if (pend[1][i]) pl.push_back(i);
      we_a = ($urandom_range(0, 1) == 1);
      wa_a = 2'($urandom_range(0, 3));
      if (pl.size() > 0 && pend[1][wa_a] && $urandom_range(0, 5) != 0) we_a = 1'b0;
      wd_a = DW'($urandom);
      we_b = ($urandom_range(0, 9) < 4);
      if (pl.size() > 0 && $urandom_range(0, 9) != 0)
        wa_b = 2'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        wa_b = 2'($urandom_range(0, 3));
      wd_b = DW'($urandom);
      ra1 = 2'($urandom_range(0, 3));
      ra2 = 2'($urandom_range(0, 3));
      pc_in = DW'($urandom);
      issue_ld = ($urandom_range(0, 2) == 0);
      issue_dst = 2'($urandom_range(0, 3));
    end

    tick();
    reset = 1'b0;
    idle();
    tick();
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
